// File: rtl/pll_scan_loader_pkg.sv
// Shared constants for the PLL scan-chain loader.
// State encoding and default chain/ROM/timeout sizes.
package pll_scan_loader_pkg;

    localparam int DEF_SCAN_LEN     = 144;
    localparam int DEF_ROM_LATENCY  = 2;
    localparam int DEF_DONE_TIMEOUT = 1023;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_READ        = 3'd1;
    localparam logic [2:0] ST_DRAIN       = 3'd2;
    localparam logic [2:0] ST_SHIFT       = 3'd3;
    localparam logic [2:0] ST_WAIT_RECONF = 3'd4;
    localparam logic [2:0] ST_UPDATE      = 3'd5;
    localparam logic [2:0] ST_WAIT_DONE   = 3'd6;

endpackage

// File: rtl/pll_scan_loader_scan_shifter.sv
// Shadow image capture and clock/2 serialiser for the PLL scan chain.
// Bit 0 goes out first; scandata only moves when scanclk falls.
module scan_shifter #(
    parameter int SCAN_LEN = 144
) (
    input  logic clock,
    input  logic reset,
    input  logic i_cap_en,
    input  logic i_cap_bit,
    input  logic i_start,
    output logic o_done,
    output logic o_scanclk,
    output logic o_scanclkena,
    output logic o_scandata
);

    logic [SCAN_LEN-1:0] r_shadow;
    logic [7:0]          r_wr_cnt;
    logic [7:0]          r_bit;
    logic                r_ena;
    logic                r_clk;
    logic                r_data;
    logic                w_last;

    assign w_last       = (r_bit == 8'(SCAN_LEN - 1));
    assign o_done       = r_ena & r_clk & w_last;
    assign o_scanclk    = r_clk;
    assign o_scanclkena = r_ena;
    assign o_scandata   = r_data;

    // Image contents need no reset; every load rewrites all bits.
    always_ff @(posedge clock) begin
        if (i_cap_en)
            r_shadow[r_wr_cnt] <= i_cap_bit;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_cnt <= 8'd0;
            r_bit    <= 8'd0;
            r_ena    <= 1'b0;
            r_clk    <= 1'b0;
            r_data   <= 1'b0;
        end else begin
            r_wr_cnt <= i_cap_en ? r_wr_cnt + 8'd1 : 8'd0;
            if (i_start) begin
                r_ena  <= 1'b1;
                r_clk  <= 1'b0;
                r_bit  <= 8'd0;
                r_data <= r_shadow[0];
            end else if (r_ena) begin
                if (!r_clk) begin
                    r_clk <= 1'b1;
                end else if (w_last) begin
                    r_ena  <= 1'b0;
                    r_clk  <= 1'b0;
                    r_data <= 1'b0;
                end else begin
                    r_clk  <= 1'b0;
                    r_bit  <= r_bit + 8'd1;
                    r_data <= r_shadow[r_bit + 8'd1];
                end
            end
        end
    end

endmodule

// File: rtl/pll_scan_loader.sv
// Reads the PLL image from the reconfig ROM, shifts it into the
// PLL scan chain and commits it with configupdate.
module pll_scan_loader
    import pll_scan_loader_pkg::*;
#(
    parameter int SCAN_LEN     = DEF_SCAN_LEN,
    parameter int ROM_LATENCY  = DEF_ROM_LATENCY,
    parameter int DONE_TIMEOUT = DEF_DONE_TIMEOUT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       trigger_read,
    input  logic       q,
    input  logic       reconfig,
    input  logic       scandone,
    output logic [7:0] address,
    output logic       read_ena,
    output logic       busy,
    output logic       scanclk,
    output logic       scanclkena,
    output logic       scandata,
    output logic       configupdate,
    output logic       error
);

    logic [2:0]             r_state;
    logic [7:0]             r_addr;
    logic                   r_rena;
    logic                   r_busy;
    logic                   r_cu;
    logic                   r_err;
    logic                   r_seen;
    logic [9:0]             r_cnt;
    logic [ROM_LATENCY-1:0] r_rv;
    logic                   w_start;
    logic                   w_shift_done;
    logic                   w_tmo;

    assign address      = r_addr;
    assign read_ena     = r_rena;
    assign busy         = r_busy;
    assign configupdate = r_cu;
    assign error        = r_err;

    assign w_start = (r_state == ST_DRAIN) &&
                     (r_cnt == 10'(ROM_LATENCY - 1));
    assign w_tmo   = (r_cnt == 10'(DONE_TIMEOUT - 1));

    // r_rv delays read_ena by the ROM latency to mark valid q bits.
    scan_shifter #(.SCAN_LEN(SCAN_LEN)) u_shift (
        .clock       (clock),
        .reset       (reset),
        .i_cap_en    (r_rv[ROM_LATENCY-1]),
        .i_cap_bit   (q),
        .i_start     (w_start),
        .o_done      (w_shift_done),
        .o_scanclk   (scanclk),
        .o_scanclkena(scanclkena),
        .o_scandata  (scandata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_addr  <= 8'd0;
            r_rena  <= 1'b0;
            r_busy  <= 1'b0;
            r_cu    <= 1'b0;
            r_err   <= 1'b0;
            r_seen  <= 1'b0;
            r_cnt   <= 10'd0;
            r_rv    <= '0;
        end else begin
            r_rv <= ROM_LATENCY'({r_rv, r_rena});
            r_cu <= 1'b0;
            if (reconfig && r_state != ST_IDLE)
                r_seen <= 1'b1;
            unique case (r_state)
                ST_IDLE: begin
                    r_seen <= 1'b0;
                    if (trigger_read) begin
                        r_state <= ST_READ;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                        r_rena  <= 1'b1;
                        r_addr  <= 8'd0;
                    end
                end
                ST_READ: begin
                    if (r_addr == 8'(SCAN_LEN - 1)) begin
                        r_rena  <= 1'b0;
                        r_addr  <= 8'd0;
                        r_cnt   <= 10'd0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_addr <= r_addr + 8'd1;
                    end
                end
                ST_DRAIN: begin
                    if (w_start)
                        r_state <= ST_SHIFT;
                    else
                        r_cnt <= r_cnt + 10'd1;
                end
                ST_SHIFT: begin
                    if (w_shift_done) begin
                        r_cnt   <= 10'd0;
                        r_state <= ST_WAIT_RECONF;
                    end
                end
                ST_WAIT_RECONF: begin
                    if (r_seen) begin
                        r_cu    <= 1'b1;
                        r_state <= ST_UPDATE;
                    end else if (w_tmo) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_seen  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                ST_UPDATE: begin
                    r_cnt   <= 10'd0;
                    r_state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (scandone || w_tmo) begin
                        r_err   <= ~scandone;
                        r_busy  <= 1'b0;
                        r_seen  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_scan_loader.sv
// Randomised bench for pll_scan_loader against a cycle-timeline model
// derived from trigger, reconfig and scandone times.
module tb_pll_scan_loader;

    localparam int N    = 144;
    localparam int NONE = 1000000000;

    logic       clock = 1'b0;
    logic       reset;
    logic       trigger_read;
    logic       q = 1'b0;
    logic       reconfig;
    logic       scandone;
    logic [7:0] address;
    logic       read_ena;
    logic       busy;
    logic       scanclk;
    logic       scanclkena;
    logic       scandata;
    logic       configupdate;
    logic       error;

    pll_scan_loader dut (
        .clock       (clock),
        .reset       (reset),
        .trigger_read(trigger_read),
        .q           (q),
        .reconfig    (reconfig),
        .scandone    (scandone),
        .address     (address),
        .read_ena    (read_ena),
        .busy        (busy),
        .scanclk     (scanclk),
        .scanclkena  (scanclkena),
        .scandata    (scandata),
        .configupdate(configupdate),
        .error       (error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    int t_trg = NONE;
    int t_rec = NONE;
    int t_done = NONE;
    int t_rst = -1;
    int t_xtrg = NONE;
    int m_u = -1;
    int m_end = NONE;
    bit m_err = 1'b0;
    bit err_prev = 1'b0;
    bit [N-1:0] img = '0;

    int fin_cyc = -1;
    int l_re = -1, l_rise = -1, l_cu = -1, l_busy = -1;
    int l_first = -1, l_last = -1, l_err = -1;

    int cnt_re = 0, cnt_rise = 0, cnt_cu = 0, cnt_busy = 0;
    int first_sd = -1, last_sd = -1;
    logic prev_ck = 1'b0;

    // ROM with two cycles from address to q
    logic p1 = 1'b0;
    always @(posedge clock) begin
        p1 <= (read_ena && address < 8'(N)) ? img[address] : 1'b0;
        q  <= p1;
    end

    // Timeline: read T+1..T+144, shift from T+147 for 288 cycles,
    // wait-for-reconfig from T+435, then update / wait-for-done.
    function automatic void plan();
        int w;
        int x;
        w = t_trg + 435;
        x = (t_rec + 1 > w) ? t_rec + 1 : w;
        if (t_rec >= t_trg + 1 && x <= w + 1022) begin
            m_u = x + 1;
            if (t_done >= m_u + 1 && t_done <= m_u + 1023) begin
                m_end = t_done + 1;
                m_err = 1'b0;
            end else begin
                m_end = m_u + 1024;
                m_err = 1'b1;
            end
        end else begin
            m_u   = -1;
            m_end = w + 1023;
            m_err = 1'b1;
        end
    endfunction

    function automatic logic [14:0] expv(input int c);
        int d;
        int s;
        logic re;
        logic en;
        logic [7:0] a;
        d = c - t_trg;
        s = t_trg + 147;
        if (t_rst >= 0 && c > t_rst) return '0;
        if (c <= t_trg) return {14'd0, err_prev};
        if (c >= m_end) return {14'd0, m_err};
        re = (d >= 1 && d <= N);
        a  = re ? 8'(d - 1) : 8'd0;
        en = (c >= s && c < s + 2 * N);
        return {1'b1, re, a, en && ((c - s) % 2 == 1), en,
                en && img[(c - s) / 2], c == m_u, 1'b0};
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, got, want);
        end
    endtask

    logic [14:0] outs;
    logic [14:0] e;
    assign outs = {busy, read_ena, address, scanclk, scanclkena,
                   scandata, configupdate, error};

    always @(negedge clock) begin
        if (cyc >= 1) begin
            e = expv(cyc);
            n_cmp++;
            if (outs !== e) begin
                n_bad++;
                if (n_bad <= 20)
                    $display("FAIL outputs cycle %0d: got %h, required %h",
                             cyc, outs, e);
            end
            if (cyc == 2)
                chk("reset_state", int'(outs), 0);
            if (cyc == t_trg + 1)
                chk("start_T+1", int'(outs[14:5]), 'h300);
            if (t_rst >= 0 && cyc == t_rst + 1)
                chk("reset_abort", int'(outs), 0);
            if (cyc == t_trg) begin
                cnt_re = 0; cnt_rise = 0; cnt_cu = 0; cnt_busy = 0;
                first_sd = -1; last_sd = -1;
            end else if (cyc > t_trg) begin
                cnt_re   += int'(read_ena);
                cnt_cu   += int'(configupdate);
                cnt_busy += int'(busy);
                if (scanclk && !prev_ck) begin
                    if (cnt_rise == 0) first_sd = int'(scandata);
                    last_sd = int'(scandata);
                    cnt_rise++;
                end
            end
            prev_ck = scanclk;
            if (cyc == fin_cyc) begin
                if (l_re >= 0)    chk("read_ena_cycles", cnt_re, l_re);
                if (l_rise >= 0)  chk("scanclk_rises", cnt_rise, l_rise);
                if (l_cu >= 0)    chk("configupdate_pulses", cnt_cu, l_cu);
                if (l_busy >= 0)  chk("busy_cycles", cnt_busy, l_busy);
                if (l_first >= 0) chk("first_scandata", first_sd, l_first);
                if (l_last >= 0)  chk("last_scandata", last_sd, l_last);
                if (l_err >= 0)   chk("error_final", int'(error), l_err);
                chk("busy_final", int'(busy), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        cyc++;
        #1;
        reset        = (cyc < 3) || (cyc == t_rst);
        trigger_read = (cyc == t_trg) || (cyc == t_xtrg);
        reconfig     = (cyc == t_rec);
        scandone     = (cyc == t_done);
    endtask

    task automatic run_scn(input int rec_off, input int done_off,
                           input int rst_off, input int xtrg_off,
                           input int lre, input int lrise, input int lcu,
                           input int lbusy, input int lfirst,
                           input int llast, input int lerr);
        int endc;
        t_trg  = cyc + 3;
        t_rec  = (rec_off < 0) ? NONE : t_trg + rec_off;
        t_rst  = (rst_off < 0) ? -1 : t_trg + rst_off;
        t_xtrg = (xtrg_off < 0) ? NONE : t_trg + xtrg_off;
        t_done = NONE;
        plan();
        if (done_off >= 0 && m_u >= 0) begin
            t_done = m_u + done_off;
            plan();
        end
        endc = (t_rst >= 0) ? t_rst + 1 : m_end;
        l_re = lre; l_rise = lrise; l_cu = lcu; l_busy = lbusy;
        l_first = lfirst; l_last = llast; l_err = lerr;
        fin_cyc = endc + 2;
        while (cyc < endc + 3) tick();
        err_prev = (t_rst >= 0) ? 1'b0 : m_err;
    endtask

    task automatic rand_img();
        for (int i = 0; i < N; i++) img[i] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        reset        = 1'b1;
        trigger_read = 1'b0;
        reconfig     = 1'b0;
        scandone     = 1'b0;
        repeat (5) tick();

        for (int i = 0; i < N; i++) img[i] = (i % 2 == 0);
        run_scn(148, 3, -1, -1, 144, 144, 1, 439, 1, 0, 0);
        run_scn(148, 5, -1, 200, 144, 144, 1, -1, 1, 0, 0);

        rand_img();
        run_scn(-1, -1, -1, -1, 144, 144, 0, 1457, -1, -1, 1);
        rand_img();
        run_scn(150, -1, -1, -1, 144, 144, 1, 1459, -1, -1, 1);
        rand_img();
        run_scn($urandom_range(1, 700), $urandom_range(1, 40), -1, -1,
                144, 144, 1, -1, int'(img[0]), int'(img[N-1]), 0);

        for (int i = 0; i < N; i++) img[i] = (i % 2 == 0);
        run_scn(150, 3, 287, -1, 144, 70, 0, 287, 1, -1, 0);
        rand_img();
        run_scn(148, 3, -1, -1, 144, 144, 1, 439,
                int'(img[0]), int'(img[N-1]), 0);

        img = '0;
        img[0] = 1'b1;
        run_scn(148, 3, -1, -1, 144, 144, 1, 439, 1, 0, 0);

        for (int k = 0; k < 3; k++) begin
            rand_img();
            run_scn($urandom_range(1, 700), $urandom_range(1, 60), -1,
                    (k == 1) ? $urandom_range(10, 400) : -1,
                    144, 144, 1, -1, int'(img[0]), int'(img[N-1]), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_scan_loader.md
# pll_scan_loader

Streams a 144-bit PLL configuration image from `pll_reconf_rom` into the PLL scan chain and commits it. The loader sits directly downstream of the ROM: it drives the ROM's `address`/`read_ena` inputs, captures the ROM's `q` bit stream into a local shadow register, and consumes its `reconfig` strobe. It then shifts the image into the PLL over `scanclk`/`scandata` and pulses `configupdate`. Its `busy` output drives the ROM's `pll_reconf_busy` input.

## Interface
- `SCAN_LEN`, 144, scan-chain length in bits; also the number of ROM addresses read (0..SCAN_LEN-1).
- `ROM_LATENCY`, 2, cycles from `address` presented to matching `q` bit.
- `DONE_TIMEOUT`, 1023, maximum cycles to wait for `reconfig` or `scandone`.
- `clock` in 1: single system clock.
- `reset` in 1: synchronous, active-high.
- `trigger_read` in 1: start pulse from ROM.
- `q` in 1: ROM data bit.
- `reconfig` in 1: ROM commit strobe (one cycle).
- `scandone` in 1: PLL reconfiguration complete.
- `address` out 8: ROM bit address.
- `read_ena` out 1: ROM read window.
- `busy` out 1: high from accepted trigger until return to IDLE.
- `scanclk` out 1: PLL scan clock, clock/2.
- `scanclkena` out 1: scan enable.
- `scandata` out 1: serial configuration bit.
- `configupdate` out 1: one-cycle commit pulse to PLL.
- `error` out 1: sticky timeout flag, cleared on next accepted trigger.

## Operation
- All outputs reset to 0; state = IDLE.
- IDLE: `trigger_read`=1 → READ, `busy`←1, `error`←0, `address`←0. A trigger in any other state is ignored.
- READ: `read_ena`=1 for exactly SCAN_LEN consecutive cycles; `address` increments 0..SCAN_LEN-1, then returns to 0 with `read_ena`=0. The `q` value sampled ROM_LATENCY cycles after address k is stored as shadow bit k; a write counter tracks captures. READ → DRAIN.
- DRAIN: ROM_LATENCY cycles to collect the last bits, then → SHIFT.
- Reconfig latch: a `reconfig` pulse in any non-IDLE state sets `reconf_seen`. The flag clears on entry to IDLE.
- SHIFT: `scanclkena`=1; `scanclk` toggles every cycle, starting low. `scandata` changes only on cycles where `scanclk` goes low. Bit 0 (address 0) is shifted first; SCAN_LEN bits take 2·SCAN_LEN cycles. On the final falling edge: `scanclkena`←0, `scanclk` held low. SHIFT → WAIT_RECONF.
- WAIT_RECONF: if `reconf_seen` → UPDATE. Otherwise count; at DONE_TIMEOUT set `error` and → IDLE.
- UPDATE: `configupdate`=1 for one cycle, then → WAIT_DONE.
- WAIT_DONE: on `scandone`=1 → IDLE. On timeout set `error` and → IDLE.
- `busy` is 0 only in IDLE.
- Counters: the address, capture and shift counters are 8-bit and saturate-free within SCAN_LEN ≤ 255. The timeout counter is 10 bits.
- A synchronous `reset` in any state aborts immediately: all outputs 0 and the shadow register contents are don't-care.

## Timing
- Trigger at cycle T → `busy`=1, `read_ena`=1, `address`=0 at T+1.
- `read_ena` is high for cycles T+1..T+SCAN_LEN.
- The ROM's `reconfig` arrives 3 cycles after `read_ena` falls, so it is seen during DRAIN or SHIFT.
- SHIFT begins at T+SCAN_LEN+ROM_LATENCY+1 and lasts 2·SCAN_LEN cycles.
- `configupdate` is asserted 2 cycles after SHIFT ends when `reconf_seen` is already set.
- `busy` falls the cycle after `scandone` is sampled high.
- Minimum trigger-to-idle time with the defaults is about 440 cycles.

## Structure
- Shared package/defines holds the state encoding (IDLE, READ, DRAIN, SHIFT, WAIT_RECONF, UPDATE, WAIT_DONE) and the SCAN_LEN default, alongside the existing `MODE_*` defines.
- One sub-module: `scan_shifter`, which owns the SCAN_LEN shadow register, the clock/2 `scanclk` generator and `scandata` serialisation, with a start/done handshake.
- The FSM and ROM addressing stay in `pll_scan_loader`.

## Test plan
- ROM model with latency 2 holding alternating 1010…: trigger → exactly 144 `read_ena` cycles, `scandata` sequence 1,0,1,0… on `scanclk` falling edges, 144 `scanclk` rising edges, one `configupdate`, `busy` low after `scandone`.
- Second trigger asserted mid-SHIFT → ignored; address sequence and scan stream unchanged, exactly one `configupdate`.
- `reconfig` never pulsed → `error`=1 after 1023 cycles in WAIT_RECONF, no `configupdate`, `busy`=0.
- `scandone` held low → `error`=1 after 1023 cycles in WAIT_DONE; the next trigger clears `error` and completes normally.
- `reset` asserted at shift bit 70 → next cycle all outputs 0. A new trigger then replays the full 144-bit stream from bit 0.
- Image with bit 0 = 1 and bit 143 = 0 (walking-one pattern) → first `scandata` bit is 1, last is 0, confirming capture alignment at ROM_LATENCY = 2.
